// File: rtl/sdfm_pkg.sv
// rtl/sdfm_pkg.sv - shared defaults, FSM states and width helper for the SDFM result arbiter
package sdfm_pkg;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_PRESENT
  } arb_state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdfm_result_arb_if.sv
// rtl/sdfm_result_arb_if.sv - granted-result output stream between arbiter and consumer
interface sdfm_result_arb_if
  import sdfm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) ();

  logic [DW-1:0]          out_data;
  logic [chan_w(NCH)-1:0] out_chan;
  logic                   out_valid;
  logic                   out_ready;

  modport master (output out_data, output out_chan, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_chan, input  out_valid, output out_ready);

endinterface

// File: rtl/sdfm_rr_pick.sv
// rtl/sdfm_rr_pick.sv - combinational round-robin pick starting at ptr
module sdfm_rr_pick
  import sdfm_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]         req,
  input  logic [chan_w(NCH)-1:0] ptr,
  output logic                   valid,
  output logic [chan_w(NCH)-1:0] idx
);

  localparam int CW = chan_w(NCH);

  logic [CW-1:0] cand;

  // Walk offsets from far to near so the request closest to ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = ptr + CW'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdfm_result_arb.sv
// rtl/sdfm_result_arb.sv - per-channel holding registers with round-robin result arbitration
module sdfm_result_arb
  import sdfm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic                SYSCLK,
  input  logic                SYSRST,
  input  logic [NCH*DW-1:0]   ch_data_in,
  input  logic [NCH-1:0]      ch_update_in,
  input  logic [NCH-1:0]      reg_chen,
  input  logic [NCH-1:0]      reg_ovfclr,
  output logic [NCH-1:0]      pend,
  output logic [NCH-1:0]      ovf_flag,
  sdfm_result_arb_if.master   out_if
);

  localparam int CW = chan_w(NCH);

  arb_state_t    state_q, state_d;
  logic [DW-1:0] hold_q [NCH];
  logic [NCH-1:0] pend_q, ovf_q, req, grant_oh;
  logic [CW-1:0] ptr_q, pick_idx, chan_q;
  logic [DW-1:0] data_q;
  logic          pick_valid, grant_en, do_grant;

  // A disabled channel drops its pend next edge, so it must not win in the meantime.
  assign req = pend_q & reg_chen;

  sdfm_rr_pick #(.NCH(NCH)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    grant_en = 1'b0;
    state_d  = state_q;
    case (state_q)
      ARB_IDLE: begin
        grant_en = 1'b1;
        if (pick_valid) state_d = ARB_PRESENT;
      end
      ARB_PRESENT: begin
        if (out_if.out_ready) begin
          grant_en = 1'b1;
          if (!pick_valid) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign do_grant = grant_en & pick_valid;

  always_comb begin
    grant_oh = '0;
    if (do_grant) grant_oh[pick_idx] = 1'b1;
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      pend_q <= '0;
      ovf_q  <= '0;
      for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!reg_chen[k]) begin
          pend_q[k] <= 1'b0;
        end else if (ch_update_in[k]) begin
          hold_q[k] <= ch_data_in[k*DW +: DW];
          pend_q[k] <= 1'b1;
        end else if (grant_oh[k]) begin
          pend_q[k] <= 1'b0;
        end
        // Overrun only when the old word is still stranded; a same-cycle grant rescues it.
        if (reg_chen[k] && ch_update_in[k] && pend_q[k] && !grant_oh[k]) ovf_q[k] <= 1'b1;
        else if (reg_ovfclr[k])                                           ovf_q[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      data_q <= '0;
      chan_q <= '0;
      ptr_q  <= '0;
    end else if (do_grant) begin
      data_q <= hold_q[pick_idx];
      chan_q <= pick_idx;
      ptr_q  <= pick_idx + CW'(1);
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_chan  = chan_q;
  assign out_if.out_valid = (state_q == ARB_PRESENT);
  assign pend             = pend_q;
  assign ovf_flag         = ovf_q;

endmodule

// File: tb/tb_sdfm_result_arb.sv
// tb/tb_sdfm_result_arb.sv - directed scoreboard bench for sdfm_result_arb
module tb_sdfm_result_arb;
  import sdfm_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 32;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } exp_t;

  logic              SYSCLK = 1'b0;
  logic              SYSRST = 1'b1;
  logic [NCH*DW-1:0] ch_data_in   = '0;
  logic [NCH-1:0]    ch_update_in = '0;
  logic [NCH-1:0]    reg_chen     = '1;
  logic [NCH-1:0]    reg_ovfclr   = '0;
  logic [NCH-1:0]    pend, ovf_flag;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  sdfm_result_arb_if #(.NCH(NCH), .DW(DW)) oif ();

  sdfm_result_arb #(.NCH(NCH), .DW(DW)) dut (
    .SYSCLK       (SYSCLK),
    .SYSRST       (SYSRST),
    .ch_data_in   (ch_data_in),
    .ch_update_in (ch_update_in),
    .reg_chen     (reg_chen),
    .reg_ovfclr   (reg_ovfclr),
    .pend         (pend),
    .ovf_flag     (ovf_flag),
    .out_if       (oif)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] d);
    ch_data_in[k*DW +: DW] = d;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    exp_t e;
    e.chan = 2'(k);
    e.data = d;
    sb.push_back(e);
  endtask

  // Accepted words are checked at the falling edge before the rising edge that takes them.
  task automatic monitor();
    exp_t e;
    if (oif.out_valid === 1'b1 && oif.out_ready === 1'b1) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_chan", oif.out_chan, e.chan);
        chk("sb_data", oif.out_data, e.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge SYSCLK);
    monitor();
    @(posedge SYSCLK);
    #1;
  endtask

  initial begin
    oif.out_ready = 1'b1;
    #1;
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_data",  oif.out_data, 0);
    chk("rst_chan",  oif.out_chan, 0);
    chk("rst_pend",  pend, 0);
    chk("rst_ovf",   ovf_flag, 0);
    @(posedge SYSCLK);
    @(posedge SYSCLK);
    #1;
    SYSRST = 1'b0;

    // Fairness: all channels at once, twice, must both start at channel 0.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NCH; k++) begin
        set_ch(k, 32'(32'hF0 + r * 16 + k));
        push(k, 32'(32'hF0 + r * 16 + k));
      end
      ch_update_in = 4'hF;
      tick();
      ch_update_in = '0;
      chk("fair_pend", pend, 4'hF);
      for (int k = 0; k < NCH; k++) begin
        tick();
        chk("fair_valid", oif.out_valid, 1);
        chk("fair_chan", oif.out_chan, k);
      end
      tick();
      chk("fair_idle", oif.out_valid, 0);
      chk("fair_drain", sb.size(), 0);
    end

    // Single word latency on channel 1.
    set_ch(1, 32'h0000_1234);
    push(1, 32'h0000_1234);
    ch_update_in = 4'b0010;
    tick();
    ch_update_in = '0;
    chk("single_pend", pend, 4'b0010);
    chk("single_early", oif.out_valid, 0);
    tick();
    chk("single_valid", oif.out_valid, 1);
    chk("single_chan", oif.out_chan, 1);
    chk("single_data", oif.out_data, 32'h0000_1234);
    chk("single_pend0", pend, 0);
    tick();
    chk("single_oneshot", oif.out_valid, 0);
    chk("single_drain", sb.size(), 0);

    // Update in the very cycle the channel is granted: old word out, new word kept.
    set_ch(2, 32'h31);
    push(2, 32'h31);
    ch_update_in = 4'b0100;
    tick();
    set_ch(2, 32'h32);
    push(2, 32'h32);
    tick();
    ch_update_in = '0;
    chk("same_data0", oif.out_data, 32'h31);
    chk("same_pend", pend, 4'b0100);
    chk("same_ovf", ovf_flag, 0);
    tick();
    chk("same_data1", oif.out_data, 32'h32);
    tick();
    chk("same_idle", oif.out_valid, 0);
    chk("same_drain", sb.size(), 0);

    // Backpressure hold.
    oif.out_ready = 1'b0;
    set_ch(2, 32'hA5A5_A5A5);
    push(2, 32'hA5A5_A5A5);
    ch_update_in = 4'b0100;
    tick();
    ch_update_in = '0;
    tick();
    chk("bp_valid0", oif.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", oif.out_valid, 1);
      chk("bp_chan", oif.out_chan, 2);
      chk("bp_data", oif.out_data, 32'hA5A5_A5A5);
    end
    oif.out_ready = 1'b1;
    tick();
    chk("bp_done", oif.out_valid, 0);
    chk("bp_drain", sb.size(), 0);

    // Overrun on channel 0 while the output is busy with channel 1.
    oif.out_ready = 1'b0;
    set_ch(1, 32'h77);
    push(1, 32'h77);
    ch_update_in = 4'b0010;
    tick();
    ch_update_in = '0;
    tick();
    chk("ovr_busy_chan", oif.out_chan, 1);
    set_ch(0, 32'h11);
    ch_update_in = 4'b0001;
    tick();
    chk("ovr_pend", pend, 4'b0001);
    chk("ovr_none", ovf_flag, 0);
    set_ch(0, 32'h22);
    push(0, 32'h22);
    tick();
    ch_update_in = '0;
    chk("ovr_set", ovf_flag, 4'b0001);
    oif.out_ready = 1'b1;
    tick();
    chk("ovr_chan", oif.out_chan, 0);
    chk("ovr_data", oif.out_data, 32'h22);
    tick();
    chk("ovr_idle", oif.out_valid, 0);
    chk("ovr_sticky", ovf_flag, 4'b0001);
    reg_ovfclr = 4'b0001;
    tick();
    reg_ovfclr = '0;
    chk("ovr_clr", ovf_flag, 0);
    chk("ovr_drain", sb.size(), 0);

    // Set beats clear on channel 3, then disabling drops its pending word.
    oif.out_ready = 1'b0;
    set_ch(1, 32'h55);
    push(1, 32'h55);
    ch_update_in = 4'b0010;
    tick();
    ch_update_in = '0;
    tick();
    set_ch(3, 32'h01);
    ch_update_in = 4'b1000;
    tick();
    set_ch(3, 32'h02);
    reg_ovfclr = 4'b1000;
    tick();
    ch_update_in = '0;
    reg_ovfclr = '0;
    chk("edge_ovf_wins", ovf_flag, 4'b1000);
    reg_chen = 4'b0111;
    tick();
    chk("edge_pend_drop", pend, 0);
    oif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("edge_no_ch3", oif.out_valid, 0);
    end
    reg_chen = 4'hF;
    reg_ovfclr = 4'b1000;
    tick();
    reg_ovfclr = '0;
    chk("edge_clr", ovf_flag, 0);
    chk("edge_drain", sb.size(), 0);

    // Asynchronous reset while presenting with three words pending.
    oif.out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 32'(32'hC0DE_0000 + k));
    ch_update_in = 4'hF;
    tick();
    ch_update_in = '0;
    tick();
    chk("mid_valid", oif.out_valid, 1);
    chk("mid_pend3", $countones(pend), 3);
    #2;
    SYSRST = 1'b1;
    #1;
    chk("arst_valid", oif.out_valid, 0);
    chk("arst_data", oif.out_data, 0);
    chk("arst_chan", oif.out_chan, 0);
    chk("arst_pend", pend, 0);
    chk("arst_ovf", ovf_flag, 0);
    @(posedge SYSCLK);
    #1;
    SYSRST = 1'b0;
    oif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", oif.out_valid, 0);
    end
    chk("final_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
